// File: rtl/project_pkg.sv
// rtl/project_pkg.sv - shared types, sizes and slot-addressing helpers for the matrix slot bank
package project_pkg;

  localparam int MAX_ROWS      = 5;
  localparam int MAX_COLS      = 5;
  localparam int ELEM_W        = 8;
  localparam int SLOTS_PER_DIM = 4;

  localparam int ROW_IDX_W = $clog2(MAX_ROWS + 1);
  localparam int COL_IDX_W = $clog2(MAX_COLS + 1);
  localparam int PTR_W     = $clog2(SLOTS_PER_DIM + 1);
  localparam int N_SHAPES  = MAX_ROWS * MAX_COLS;
  localparam int N_SLOTS   = N_SHAPES * SLOTS_PER_DIM;
  localparam int MAT_ID_W  = $clog2(N_SLOTS);
  localparam int SHAPE_W   = $clog2(N_SHAPES);

  typedef logic signed [ELEM_W-1:0] matrix_element_t;

  typedef struct packed {
    logic [ROW_IDX_W-1:0]                          rows;
    logic [COL_IDX_W-1:0]                          cols;
    logic                                          is_valid;
    matrix_element_t [MAX_ROWS-1:0][MAX_COLS-1:0]  cells;
  } matrix_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_t;

  // A shape is legal when both dimensions are within 1..MAX.
  function automatic logic shape_legal(input logic [ROW_IDX_W-1:0] rows,
                                       input logic [COL_IDX_W-1:0] cols);
    return (rows != '0) && (int'(rows) <= MAX_ROWS) &&
           (cols != '0) && (int'(cols) <= MAX_COLS);
  endfunction

  // Row-major shape index; only meaningful for legal shapes.
  function automatic logic [SHAPE_W-1:0] shape_idx(input logic [ROW_IDX_W-1:0] rows,
                                                   input logic [COL_IDX_W-1:0] cols);
    return SHAPE_W'((int'(rows) - 1) * MAX_COLS + (int'(cols) - 1));
  endfunction

  function automatic logic [MAT_ID_W-1:0] slot_id(input logic [ROW_IDX_W-1:0] rows,
                                                  input logic [COL_IDX_W-1:0] cols,
                                                  input logic [PTR_W-1:0]     ptr);
    return MAT_ID_W'(((int'(rows) - 1) * MAX_COLS + (int'(cols) - 1)) * SLOTS_PER_DIM
                     + int'(ptr));
  endfunction

  // Shape that owns a slot ID; caller guarantees the ID is in range.
  function automatic logic [SHAPE_W-1:0] shape_of_id(input logic [MAT_ID_W-1:0] id);
    return SHAPE_W'(int'(id) / SLOTS_PER_DIM);
  endfunction

  function automatic logic [PTR_W-1:0] clamp_limit(input logic [PTR_W-1:0] lim);
    if (lim == '0) return PTR_W'(1);
    if (int'(lim) > SLOTS_PER_DIM) return PTR_W'(SLOTS_PER_DIM);
    return lim;
  endfunction

endpackage

// File: rtl/slot_alloc_ring.sv
// rtl/slot_alloc_ring.sv - per-shape ring pointers, occupancy counters and active limit
module slot_alloc_ring
  import project_pkg::*;
#(
  parameter int DEFAULT_LIMIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  input  logic [PTR_W-1:0]     cfg_limit,
  input  logic                 alloc_en,
  input  logic [ROW_IDX_W-1:0] alloc_rows,
  input  logic [COL_IDX_W-1:0] alloc_cols,
  output logic [MAT_ID_W-1:0]  alloc_id,
  input  logic                 cnt_inc,
  input  logic                 cnt_dec,
  input  logic [SHAPE_W-1:0]   cnt_shape,
  input  logic [SHAPE_W-1:0]   query_shape,
  output logic [PTR_W:0]       query_cnt
);

  localparam logic [PTR_W-1:0] RESET_LIMIT = clamp_limit(PTR_W'(DEFAULT_LIMIT));

  logic [PTR_W-1:0]   ptr [N_SHAPES];
  logic [PTR_W:0]     cnt [N_SHAPES];
  logic [PTR_W-1:0]   limit;
  logic               alloc_legal;
  logic [SHAPE_W-1:0] alloc_shape;
  logic [PTR_W-1:0]   ptr_next;

  // Slot the next allocation of the requested shape lands in, and where the ring moves after it.
  always_comb begin
    alloc_legal = shape_legal(alloc_rows, alloc_cols);
    alloc_shape = '0;
    alloc_id    = '0;
    if (alloc_legal) begin
      alloc_shape = shape_idx(alloc_rows, alloc_cols);
      alloc_id    = slot_id(alloc_rows, alloc_cols, ptr[alloc_shape]);
    end
    ptr_next = (ptr[alloc_shape] + 1'b1 == limit) ? '0 : ptr[alloc_shape] + 1'b1;
    query_cnt = cnt[query_shape];
  end

  // Ring pointers advance per allocation; counts saturate at the active limit and never go below zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      limit <= RESET_LIMIT;
      for (int i = 0; i < N_SHAPES; i++) begin
        ptr[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (cfg_valid) begin
      limit <= clamp_limit(cfg_limit);
      for (int i = 0; i < N_SHAPES; i++) begin
        ptr[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      if (alloc_en && alloc_legal) begin
        ptr[alloc_shape] <= ptr_next;
      end
      if (cnt_inc && (cnt[cnt_shape] < {1'b0, limit})) begin
        cnt[cnt_shape] <= cnt[cnt_shape] + 1'b1;
      end else if (cnt_dec && (cnt[cnt_shape] != '0)) begin
        cnt[cnt_shape] <= cnt[cnt_shape] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_slot_bank.sv
// rtl/matrix_slot_bank.sv - matrix storage bank with per-shape rings, streaming fill and read ports
module matrix_slot_bank
  import project_pkg::*;
#(
  parameter int DEFAULT_LIMIT = 2,
  parameter int N_RD          = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  input  logic [PTR_W-1:0]     cfg_limit,
  input  logic                 alloc_req,
  input  logic [ROW_IDX_W-1:0] alloc_rows,
  input  logic [COL_IDX_W-1:0] alloc_cols,
  output logic                 alloc_ack,
  output logic                 alloc_err,
  output logic [MAT_ID_W-1:0]  alloc_id,
  input  logic                 wr_valid,
  input  matrix_element_t      wr_data,
  output logic                 wr_ready,
  output logic                 wr_done,
  input  logic                 ld_valid,
  input  logic [MAT_ID_W-1:0]  ld_id,
  input  matrix_t              ld_mat,
  input  logic                 clr_valid,
  input  logic [MAT_ID_W-1:0]  clr_id,
  input  logic [MAT_ID_W-1:0]  rd_id [N_RD],
  output matrix_t              rd_data [N_RD],
  output logic                 rd_valid [N_RD],
  input  logic [ROW_IDX_W-1:0] occ_rows,
  input  logic [COL_IDX_W-1:0] occ_cols,
  output logic [PTR_W:0]       occ_cnt
);

  matrix_t             store [N_SLOTS];
  fill_state_t         state, state_d;

  logic [MAT_ID_W-1:0]  fill_id;
  logic [ROW_IDX_W-1:0] fill_rows, row_cnt;
  logic [COL_IDX_W-1:0] fill_cols, col_cnt;

  logic                 lower_ok, do_clr, do_ld, clr_ok, ld_ok;
  logic [MAT_ID_W-1:0]  clr_idx, ld_idx;
  logic                 alloc_legal, alloc_fire, alloc_bad, wr_fire, last_elem, fill_abort;
  logic [MAT_ID_W-1:0]  ring_id;
  logic                 cnt_inc, cnt_dec;
  logic [SHAPE_W-1:0]   cnt_shape, occ_shape;
  logic                 occ_legal;
  logic [PTR_W:0]       ring_cnt;
  logic                 ack_d, err_d, done_d;
  logic [MAT_ID_W-1:0]  id_d;

  // Priority: cfg > clr > ld > alloc/stream; anything above alloc/stream silences it this cycle.
  assign lower_ok    = !cfg_valid && !clr_valid && !ld_valid;
  assign do_clr      = !cfg_valid && clr_valid;
  assign do_ld       = !cfg_valid && !clr_valid && ld_valid;
  assign clr_ok      = int'(clr_id) < N_SLOTS;
  assign ld_ok       = int'(ld_id) < N_SLOTS;
  assign clr_idx     = clr_ok ? clr_id : '0;
  assign ld_idx      = ld_ok ? ld_id : '0;

  assign alloc_legal = shape_legal(alloc_rows, alloc_cols);
  assign alloc_fire  = (state == S_IDLE) && alloc_req && lower_ok && alloc_legal;
  assign alloc_bad   = (state == S_IDLE) && alloc_req && lower_ok && !alloc_legal;
  assign wr_ready    = (state == S_FILL) && lower_ok;
  assign wr_fire     = wr_ready && wr_valid;
  assign last_elem   = (row_cnt == fill_rows - 1'b1) && (col_cnt == fill_cols - 1'b1);
  assign fill_abort  = (state == S_FILL) &&
                       ((do_clr && clr_ok && (clr_id == fill_id)) ||
                        (do_ld && ld_ok && (ld_id == fill_id)));

  assign occ_legal   = shape_legal(occ_rows, occ_cols);
  assign occ_shape   = occ_legal ? shape_idx(occ_rows, occ_cols) : '0;

  slot_alloc_ring #(
    .DEFAULT_LIMIT (DEFAULT_LIMIT)
  ) u_ring (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_limit   (cfg_limit),
    .alloc_en    (alloc_fire),
    .alloc_rows  (alloc_rows),
    .alloc_cols  (alloc_cols),
    .alloc_id    (ring_id),
    .cnt_inc     (cnt_inc),
    .cnt_dec     (cnt_dec),
    .cnt_shape   (cnt_shape),
    .query_shape (occ_shape),
    .query_cnt   (ring_cnt)
  );

  // Occupancy moves only on valid-bit transitions of the slot touched by the winning operation.
  always_comb begin
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    cnt_shape = '0;
    if (do_clr && clr_ok) begin
      cnt_shape = shape_of_id(clr_id);
      cnt_dec   = store[clr_idx].is_valid;
    end else if (do_ld && ld_ok) begin
      cnt_shape = shape_of_id(ld_id);
      cnt_inc   = !store[ld_idx].is_valid && ld_mat.is_valid;
      cnt_dec   = store[ld_idx].is_valid && !ld_mat.is_valid;
    end else if (alloc_fire) begin
      cnt_shape = shape_idx(alloc_rows, alloc_cols);
      cnt_inc   = !store[ring_id].is_valid;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next state and the values the registered handshake outputs take next cycle.
  always_comb begin
    state_d = state;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    id_d    = '0;
    done_d  = 1'b0;
    if (cfg_valid) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (alloc_fire) begin
            state_d = S_FILL;
            ack_d   = 1'b1;
            id_d    = ring_id;
          end else if (alloc_bad) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end
        end
        S_FILL: begin
          if (fill_abort) begin
            state_d = S_IDLE;
          end else if (wr_fire && last_elem) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Slot storage: one write per cycle chosen by operation priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        store[i] <= '0;
      end
    end else if (cfg_valid) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        store[i].is_valid <= 1'b0;
      end
    end else if (do_clr) begin
      if (clr_ok) begin
        store[clr_idx].is_valid <= 1'b0;
      end
    end else if (do_ld) begin
      if (ld_ok) begin
        store[ld_idx] <= ld_mat;
      end
    end else if (alloc_fire) begin
      store[ring_id].rows     <= alloc_rows;
      store[ring_id].cols     <= alloc_cols;
      store[ring_id].is_valid <= 1'b1;
      store[ring_id].cells    <= '0;
    end else if (wr_fire) begin
      store[fill_id].cells[row_cnt][col_cnt] <= wr_data;
    end
  end

  // Row-major element cursor for the slot being filled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_id   <= '0;
      fill_rows <= '0;
      fill_cols <= '0;
      row_cnt   <= '0;
      col_cnt   <= '0;
    end else if (alloc_fire) begin
      fill_id   <= ring_id;
      fill_rows <= alloc_rows;
      fill_cols <= alloc_cols;
      row_cnt   <= '0;
      col_cnt   <= '0;
    end else if (wr_fire) begin
      if (col_cnt == fill_cols - 1'b1) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Registered outputs: handshakes, read ports and occupancy query.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_ack <= 1'b0;
      alloc_err <= 1'b0;
      alloc_id  <= '0;
      wr_done   <= 1'b0;
      occ_cnt   <= '0;
      for (int i = 0; i < N_RD; i++) begin
        rd_data[i]  <= '0;
        rd_valid[i] <= 1'b0;
      end
    end else begin
      alloc_ack <= ack_d;
      alloc_err <= err_d;
      alloc_id  <= id_d;
      wr_done   <= done_d;
      occ_cnt   <= occ_legal ? ring_cnt : '0;
      for (int i = 0; i < N_RD; i++) begin
        if (int'(rd_id[i]) < N_SLOTS) begin
          rd_data[i]  <= store[rd_id[i]];
          rd_valid[i] <= store[rd_id[i]].is_valid;
        end else begin
          rd_data[i]  <= '0;
          rd_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_slot_bank.sv
// tb/tb_matrix_slot_bank.sv - randomized self-checking bench for matrix_slot_bank
module tb_matrix_slot_bank;
  import project_pkg::*;

  localparam int N_RD = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 cfg_valid;
  logic [PTR_W-1:0]     cfg_limit;
  logic                 alloc_req;
  logic [ROW_IDX_W-1:0] alloc_rows;
  logic [COL_IDX_W-1:0] alloc_cols;
  logic                 alloc_ack;
  logic                 alloc_err;
  logic [MAT_ID_W-1:0]  alloc_id;
  logic                 wr_valid;
  matrix_element_t      wr_data;
  logic                 wr_ready;
  logic                 wr_done;
  logic                 ld_valid;
  logic [MAT_ID_W-1:0]  ld_id;
  matrix_t              ld_mat;
  logic                 clr_valid;
  logic [MAT_ID_W-1:0]  clr_id;
  logic [MAT_ID_W-1:0]  rd_id [N_RD];
  matrix_t              rd_data [N_RD];
  logic                 rd_valid [N_RD];
  logic [ROW_IDX_W-1:0] occ_rows;
  logic [COL_IDX_W-1:0] occ_cols;
  logic [PTR_W:0]       occ_cnt;

  matrix_slot_bank #(.DEFAULT_LIMIT(2), .N_RD(N_RD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_limit(cfg_limit),
    .alloc_req(alloc_req), .alloc_rows(alloc_rows), .alloc_cols(alloc_cols),
    .alloc_ack(alloc_ack), .alloc_err(alloc_err), .alloc_id(alloc_id),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
    .ld_valid(ld_valid), .ld_id(ld_id), .ld_mat(ld_mat),
    .clr_valid(clr_valid), .clr_id(clr_id),
    .rd_id(rd_id), .rd_data(rd_data), .rd_valid(rd_valid),
    .occ_rows(occ_rows), .occ_cols(occ_cols), .occ_cnt(occ_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: slots as whole matrices, per-shape ring position and live count.
  matrix_t m_store [N_SLOTS];
  int      m_ptr [N_SHAPES];
  int      m_cnt [N_SHAPES];
  int      m_limit;
  bit      m_fill;
  int      m_fid, m_k, m_fr, m_fc;

  function automatic bit m_legal(int r, int c);
    return r >= 1 && r <= MAX_ROWS && c >= 1 && c <= MAX_COLS;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N_SLOTS; i++) m_store[i] = '0;
    for (int s = 0; s < N_SHAPES; s++) begin
      m_ptr[s] = 0;
      m_cnt[s] = 0;
    end
    m_limit = 2;
    m_fill  = 0;
    m_fid   = 0;
    m_k     = 0;
  endfunction

  task automatic step();
    matrix_t e_rd [N_RD];
    bit      e_ack, e_err, e_done;
    int      e_id, e_occ, r, c, sh, id, lim;
    bit      old_v;
    #2;
    check("wr_ready", wr_ready, m_fill && !cfg_valid && !clr_valid && !ld_valid);
    for (int i = 0; i < N_RD; i++) begin
      e_rd[i] = '0;
      if (int'(rd_id[i]) < N_SLOTS) e_rd[i] = m_store[rd_id[i]];
    end
    e_occ = m_legal(int'(occ_rows), int'(occ_cols)) ?
            m_cnt[(int'(occ_rows) - 1) * MAX_COLS + int'(occ_cols) - 1] : 0;
    e_ack = 0; e_err = 0; e_done = 0; e_id = 0;
    r = int'(alloc_rows);
    c = int'(alloc_cols);
    if (!rst_n) begin
      m_reset();
      for (int i = 0; i < N_RD; i++) e_rd[i] = '0;
      e_occ = 0;
    end else if (cfg_valid) begin
      lim = int'(cfg_limit);
      if (lim < 1) lim = 1;
      if (lim > SLOTS_PER_DIM) lim = SLOTS_PER_DIM;
      m_limit = lim;
      for (int i = 0; i < N_SLOTS; i++) m_store[i].is_valid = 1'b0;
      for (int s = 0; s < N_SHAPES; s++) begin
        m_ptr[s] = 0;
        m_cnt[s] = 0;
      end
      m_fill = 0;
    end else if (clr_valid) begin
      id = int'(clr_id);
      if (id < N_SLOTS) begin
        if (m_store[id].is_valid) m_cnt[id / SLOTS_PER_DIM]--;
        m_store[id].is_valid = 1'b0;
        if (m_fill && m_fid == id) m_fill = 0;
      end
    end else if (ld_valid) begin
      id = int'(ld_id);
      if (id < N_SLOTS) begin
        sh    = id / SLOTS_PER_DIM;
        old_v = m_store[id].is_valid;
        if (!old_v && ld_mat.is_valid && m_cnt[sh] < m_limit) m_cnt[sh]++;
        else if (old_v && !ld_mat.is_valid) m_cnt[sh]--;
        m_store[id] = ld_mat;
        if (m_fill && m_fid == id) m_fill = 0;
      end
    end else if (!m_fill && alloc_req) begin
      e_ack = 1;
      if (m_legal(r, c)) begin
        sh = (r - 1) * MAX_COLS + (c - 1);
        id = sh * SLOTS_PER_DIM + m_ptr[sh];
        if (!m_store[id].is_valid && m_cnt[sh] < m_limit) m_cnt[sh]++;
        m_store[id] = '0;
        m_store[id].rows = alloc_rows;
        m_store[id].cols = alloc_cols;
        m_store[id].is_valid = 1'b1;
        m_ptr[sh] = (m_ptr[sh] + 1) % m_limit;
        e_id = id;
        m_fill = 1; m_fid = id; m_k = 0; m_fr = r; m_fc = c;
      end else begin
        e_err = 1;
      end
    end else if (m_fill && wr_valid) begin
      m_store[m_fid].cells[m_k / m_fc][m_k % m_fc] = wr_data;
      m_k++;
      if (m_k == m_fr * m_fc) begin
        m_fill = 0;
        e_done = 1;
      end
    end
    @(posedge clk);
    #1;
    check("alloc_ack", alloc_ack, e_ack);
    check("alloc_err", alloc_err, e_err);
    check("alloc_id", alloc_id, e_id);
    check("wr_done", wr_done, e_done);
    check("occ_cnt", occ_cnt, e_occ);
    for (int i = 0; i < N_RD; i++) begin
      check($sformatf("rd_valid%0d", i), rd_valid[i], e_rd[i].is_valid);
      check($sformatf("rd_data%0d", i), rd_data[i], e_rd[i]);
    end
  endtask

  task automatic idle_in();
    rst_n = 1'b1; cfg_valid = 1'b0; cfg_limit = '0;
    alloc_req = 1'b0; alloc_rows = '0; alloc_cols = '0;
    wr_valid = 1'b0; wr_data = '0;
    ld_valid = 1'b0; ld_id = '0; ld_mat = '0;
    clr_valid = 1'b0; clr_id = '0;
    occ_rows = '0; occ_cols = '0;
    for (int i = 0; i < N_RD; i++) rd_id[i] = '0;
  endtask

  task automatic do_alloc(input int r, input int c);
    alloc_req  = 1'b1;
    alloc_rows = ROW_IDX_W'(r);
    alloc_cols = COL_IDX_W'(c);
    step();
    alloc_req = 1'b0;
  endtask

  task automatic stream(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1;
      wr_data  = ELEM_W'(base + k);
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic rand_mat(output matrix_t m);
    m.rows     = ROW_IDX_W'($urandom);
    m.cols     = COL_IDX_W'($urandom);
    m.is_valid = 1'($urandom);
    for (int r = 0; r < MAX_ROWS; r++)
      for (int c = 0; c < MAX_COLS; c++)
        m.cells[r][c] = ELEM_W'($urandom);
  endtask

  function automatic logic [MAT_ID_W-1:0] rand_id();
    if ($urandom_range(0, 7) == 0) return MAT_ID_W'($urandom_range(0, 127));
    return MAT_ID_W'((($urandom_range(1, 3) - 1) * MAX_COLS + $urandom_range(1, 3) - 1)
                     * SLOTS_PER_DIM + $urandom_range(0, 3));
  endfunction

  matrix_t exp_m;
  int      exp_ids [5];

  initial begin
    idle_in();
    m_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;

    // alloc 2x3, stream 1..6, read it back
    rd_id[0] = 7'd28;
    do_alloc(2, 3);
    check("tp1_ack", alloc_ack, 1);
    check("tp1_id", alloc_id, 28);
    stream(6, 1);
    check("tp1_done", wr_done, 1);
    step();
    exp_m = '0;
    exp_m.rows = 3'd2;
    exp_m.cols = 3'd3;
    exp_m.is_valid = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        exp_m.cells[r][c] = ELEM_W'(r * 3 + c + 1);
    check("tp1_rd", rd_data[0], exp_m);
    check("tp1_rdv", rd_valid[0], 1);

    // ring wrap at the default limit of 2
    occ_rows = 3'd2;
    occ_cols = 3'd2;
    exp_ids = '{24, 25, 24, 0, 0};
    for (int j = 0; j < 3; j++) begin
      do_alloc(2, 2);
      check("tp2_id", alloc_id, exp_ids[j]);
      stream(4, 10 * j);
    end
    check("tp2_occ", occ_cnt, 2);

    // illegal shapes
    do_alloc(0, 3);
    check("tp3_err_a", alloc_err, 1);
    do_alloc(6, 1);
    check("tp3_err_b", alloc_err, 1);
    step();
    check("tp3_occ", occ_cnt, 2);

    // reconfigure mid-fill
    do_alloc(2, 2);
    check("tp4_id", alloc_id, 25);
    stream(3, 40);
    cfg_valid = 1'b1;
    cfg_limit = 3'd7;
    wr_valid  = 1'b1;
    #2;
    check("tp4_ready_cfg", wr_ready, 0);
    #(-0);
    step();
    cfg_valid = 1'b0;
    wr_valid  = 1'b0;
    rd_id[0]  = 7'd24;
    rd_id[1]  = 7'd25;
    step();
    check("tp4_nodone", wr_done, 0);
    check("tp4_rdv0", rd_valid[0], 0);
    check("tp4_rdv1", rd_valid[1], 0);
    check("tp4_ready", wr_ready, 0);
    exp_ids = '{24, 25, 26, 27, 24};
    for (int j = 0; j < 5; j++) begin
      do_alloc(2, 2);
      check("tp4_lim_id", alloc_id, exp_ids[j]);
      stream(4, j);
    end

    // clr and ld of the same slot in one cycle
    exp_m = '0;
    exp_m.rows = 3'd1;
    exp_m.cols = 3'd2;
    exp_m.is_valid = 1'b1;
    exp_m.cells[0][0] = 8'sd7;
    ld_mat   = exp_m;
    ld_id    = 7'd5;
    ld_valid = 1'b1;
    occ_rows = 3'd1;
    occ_cols = 3'd2;
    step();
    ld_valid = 1'b0;
    step();
    check("tp5_occ_ld", occ_cnt, 1);
    clr_valid = 1'b1;
    clr_id    = 7'd5;
    ld_valid  = 1'b1;
    step();
    clr_valid = 1'b0;
    ld_valid  = 1'b0;
    rd_id[0]  = 7'd5;
    step();
    step();
    check("tp5_rdv", rd_valid[0], 0);
    check("tp5_occ", occ_cnt, 0);

    // reset during fill
    do_alloc(1, 3);
    check("tp6_id", alloc_id, 8);
    stream(1, 99);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("tp6_ready", wr_ready, 0);
    check("tp6_ack", alloc_ack, 0);
    rd_id[0] = 7'd8;
    step();
    check("tp6_rdv", rd_valid[0], 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      cfg_valid  = ($urandom_range(0, 99) == 0);
      cfg_limit  = PTR_W'($urandom_range(0, 7));
      clr_valid  = ($urandom_range(0, 19) == 0);
      clr_id     = rand_id();
      ld_valid   = ($urandom_range(0, 19) == 0);
      ld_id      = rand_id();
      rand_mat(ld_mat);
      alloc_req  = ($urandom_range(0, 2) == 0);
      alloc_rows = ($urandom_range(0, 9) == 0) ? 3'd6 : ROW_IDX_W'($urandom_range(0, 3));
      alloc_cols = ($urandom_range(0, 9) == 0) ? 3'd6 : COL_IDX_W'($urandom_range(0, 3));
      wr_valid   = ($urandom_range(0, 3) != 0);
      wr_data    = ELEM_W'($urandom);
      rd_id[0]   = m_fill ? MAT_ID_W'(m_fid) : rand_id();
      rd_id[1]   = rand_id();
      occ_rows   = ROW_IDX_W'($urandom_range(0, 6));
      occ_cols   = COL_IDX_W'($urandom_range(0, 6));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
